bus_arbiter: RTL and testbench

Shared-bus arbiter directly downstream of the per-core cpu blocks. It collects one req_arb line from each core's cache and returns a one-hot gnt_arb vector, granting the memory bus to one core at a time. Policy is round-robin, with an optional hold limit and a fixed bus-turnaround gap between owners. All outputs are registered.

---
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter handing the shared memory bus to one
// core at a time, with an optional hold limit and a fixed dead gap
// between successive owners. All outputs are registered.
module bus_arbiter #(
  parameter int N_CPU    = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1,
  parameter int ID_W     = (N_CPU > 1) ? $clog2(N_CPU) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CPU-1:0] req_arb,
  output logic [N_CPU-1:0] gnt_arb,
  output logic [ID_W-1:0]  owner_id,
  output logic             bus_busy,
  output logic             preempt
);

  localparam int              HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [3:0]      TURN_MAX = 4'(TURN_CYC);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [3:0]         turn_cnt, turn_nxt;
  logic [ID_W-1:0]    last_owner, last_nxt;
  logic [N_CPU-1:0]   gnt_nxt;
  logic [ID_W-1:0]    owner_nxt;
  logic               busy_nxt;
  logic               preempt_nxt;

  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic [N_CPU-1:0]   own_mask;
  logic               own_req;
  logic               others_req;

  // Round-robin pick: scan downward from the farthest offset so the
  // nearest requester after last_owner overwrites and wins.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int unsigned k = N_CPU; k >= 1; k--) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((32'(last_owner) + k) % N_CPU);
      if (req_arb[idx]) begin
        win_id  = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Owner's own request and whether anyone else is waiting.
  always_comb begin
    own_mask           = '0;
    own_mask[owner_id] = 1'b1;
    own_req            = req_arb[owner_id];
    others_req         = |(req_arb & ~own_mask);
  end

  // Next-state and next-output decode.
  always_comb begin
    logic arbitrate;
    logic release_bus;
    state_nxt   = state;
    gnt_nxt     = gnt_arb;
    owner_nxt   = owner_id;
    busy_nxt    = bus_busy;
    preempt_nxt = 1'b0;
    hold_nxt    = hold_cnt;
    turn_nxt    = turn_cnt;
    last_nxt    = last_owner;
    arbitrate   = 1'b0;
    release_bus = 1'b0;

    case (state)
      IDLE: begin
        if (win_vld) arbitrate = 1'b1;
      end
      GRANT: begin
        // A dropped request takes precedence over hold-limit expiry, so a
        // simultaneous drop never raises preempt.
        if (!own_req) begin
          release_bus = 1'b1;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_MAX && others_req) begin
          release_bus = 1'b1;
          preempt_nxt = 1'b1;
        end else if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt < TURN_MAX) begin
          turn_nxt = turn_cnt + 1'b1;
        end else if (win_vld) begin
          arbitrate = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (arbitrate) begin
      state_nxt       = GRANT;
      gnt_nxt         = '0;
      gnt_nxt[win_id] = 1'b1;
      owner_nxt       = win_id;
      last_nxt        = win_id;
      hold_nxt        = HOLD_W'(1);
      busy_nxt        = 1'b1;
    end

    if (release_bus) begin
      state_nxt = TURN;
      gnt_nxt   = '0;
      busy_nxt  = 1'b0;
      turn_nxt  = 4'd1;
    end
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt_arb    <= '0;
      owner_id   <= '0;
      bus_busy   <= 1'b0;
      preempt    <= 1'b0;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      last_owner <= ID_W'(N_CPU - 1);
    end else begin
      state      <= state_nxt;
      gnt_arb    <= gnt_nxt;
      owner_id   <= owner_nxt;
      bus_busy   <= busy_nxt;
      preempt    <= preempt_nxt;
      hold_cnt   <= hold_nxt;
      turn_cnt   <= turn_nxt;
      last_owner <= last_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus random request traffic, checked
// every cycle against an owner/timer model of the arbitration rules.
module tb_bus_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int TURN = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt_arb;
  logic [1:0]   owner_id;
  logic         bus_busy;
  logic         preempt;

  int total = 0;
  int bad   = 0;

  // reference model: who owns the bus, for how long, and the gap timer
  int m_owner, m_held, m_gap, m_last;
  bit m_turn, m_pre;
  int pre_cnt;
  int order[$];

  bus_arbiter #(.N_CPU(N), .MAX_HOLD(HOLD), .TURN_CYC(TURN), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_arb(req), .gnt_arb(gnt_arb),
    .owner_id(owner_id), .bus_busy(bus_busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1;
    m_turn = 0; m_pre = 0; pre_cnt = 0;
    order.delete();
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    m_pre = 0;
    if (m_owner >= 0) begin
      others = r & ~(N'(1) << m_owner);
      if (!r[m_owner]) begin
        m_owner = -1; m_turn = 1; m_gap = 1;
      end else if (HOLD != 0 && m_held >= HOLD && others != 0) begin
        m_owner = -1; m_turn = 1; m_gap = 1; m_pre = 1;
      end else begin
        m_held++;
      end
    end else if (m_turn && m_gap < TURN) begin
      m_gap++;
    end else begin
      int c;
      m_turn = 0;
      c = rr_pick(r);
      if (c >= 0) begin
        m_owner = c; m_last = c; m_held = 1;
        order.push_back(c);
      end
    end
    if (m_pre) pre_cnt++;
  endfunction

  task automatic tick();
    logic [N-1:0] exp_gnt;
    @(posedge clk);
    model_step(req);
    #1;
    exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("gnt", 32'(gnt_arb), 32'(exp_gnt));
    check("busy", 32'(bus_busy), 32'(m_owner >= 0));
    check("preempt", 32'(preempt), 32'(m_pre));
    if (m_owner >= 0) check("owner", 32'(owner_id), m_owner);
  endtask

  // assert reset between clock edges and confirm outputs clear at once
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt_arb), 0);
    check("rst_busy", 32'(bus_busy), 0);
    check("rst_pre", 32'(preempt), 0);
    check("rst_owner", 32'(owner_id), 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic check_order(input string tag, input int e0, input int e1, input int e2,
                             input int e3, input int e4, input int n);
    int exp[5];
    exp = '{e0, e1, e2, e3, e4};
    check({tag, "_len"}, order.size() >= n, 1);
    for (int k = 0; k < n; k++)
      check(tag, (k < order.size()) ? order[k] : -1, exp[k]);
  endtask

  initial begin
    bit done1, dropped;
    model_reset();
    do_reset();

    // single requester, then drop -> back to idle
    req = 4'b0001;
    for (int c = 0; c < 5; c++) tick();
    req = 4'b0000;
    for (int c = 0; c < 4; c++) tick();

    // everyone requesting, each drops 3 cycles into its grant
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        req[i] = !(m_owner == i && m_held == 3);
    end
    check_order("rr_order", 0, 1, 2, 3, 0, 5);
    req = '0;
    for (int c = 0; c < 3; c++) tick();

    // hold-limit preemption of core 2 by core 1
    do_reset();
    done1 = 0;
    for (int c = 0; c < 30; c++) begin
      req[2] = (c < 20);
      req[1] = (c >= 3) && !done1;
      tick();
      if (m_owner == 1 && m_held >= 4) done1 = 1;
      req[1] = (c + 1 >= 3) && !done1;
    end
    check("preempt_cnt3", pre_cnt, 1);
    check_order("pre_order", 2, 1, 2, 0, 0, 3);

    // lone requester is never preempted
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 30; c++) tick();
    check("preempt_cnt4", pre_cnt, 0);
    req = '0;
    for (int c = 0; c < 3; c++) tick();

    // owner drops exactly when the hold limit is reached: release, not preempt
    do_reset();
    req = 4'b1001;
    dropped = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (m_owner == 0 && m_held == HOLD) dropped = 1;
      req[0] = !dropped;
    end
    check("preempt_cnt5", pre_cnt, 0);
    check_order("drop_order", 0, 3, 0, 0, 0, 2);
    req = '0;
    for (int c = 0; c < 3; c++) tick();

    // reset mid-grant restores core 0 as first choice
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 3; c++) tick();
    do_reset();
    req = 4'b1001;
    for (int c = 0; c < 3; c++) tick();
    check_order("rst_order", 0, 0, 0, 0, 0, 1);
    req = '0;
    tick();

    // random traffic: slow toggling reaches the hold limit, fast toggling
    // exercises skipped requesters
    do_reset();
    for (int c = 0; c < 800; c++) begin
      int rate;
      rate = (c < 400) ? 12 : 3;
      for (int i = 0; i < N; i++)
        if ($urandom_range(rate - 1) == 0) req[i] = ~req[i];
      tick();
    end
    check("rand_grants", order.size() > 20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
